// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63]
// from a 16-word sliding window with valid/ready backpressure.
module sha256_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ABORT,
  input  logic [WORD_W-1:0] WORD_IN,
  input  logic              WORD_VALID,
  output logic              WORD_READY,
  output logic [WORD_W-1:0] W_OUT,
  output logic [5:0]        W_ROUND,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              BLOCK_DONE,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t            r_state;
  logic [3:0]        r_lcnt;
  logic [5:0]        r_rcnt;
  logic [WORD_W-1:0] r_win [16];

  logic              w_load_acc;
  logic              w_run_acc;
  logic              w_shift;
  logic [WORD_W-1:0] w_next;
  logic [WORD_W-1:0] w_in;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_load_acc = (r_state == S_LOAD) && WORD_VALID;
  assign w_run_acc  = (r_state == S_RUN) && W_READY;
  assign w_shift    = !ABORT && (w_load_acc || w_run_acc);

  assign w_next = sig1(r_win[14]) + r_win[9]
                + sig0(r_win[1]) + r_win[0];
  assign w_in   = (r_state == S_LOAD) ? WORD_IN : w_next;

  // Window: shift oldest out, new message or expanded word in
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (w_shift) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_in;
    end
  end

  // Control FSM with load and round counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_LOAD;
      r_lcnt  <= '0;
      r_rcnt  <= '0;
    end else if (ABORT) begin
      r_state <= S_LOAD;
      r_lcnt  <= '0;
      r_rcnt  <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (WORD_VALID) begin
            if (r_lcnt == 4'd15) begin
              r_lcnt  <= '0;
              r_rcnt  <= '0;
              r_state <= S_RUN;
            end else begin
              r_lcnt <= r_lcnt + 4'd1;
            end
          end
        end
        S_RUN: begin
          if (W_READY) begin
            r_rcnt <= r_rcnt + 6'd1;
            if (r_rcnt == LAST) begin
              r_rcnt  <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_lcnt  <= '0;
          r_state <= S_LOAD;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign WORD_READY = (r_state == S_LOAD);
  assign W_VALID    = (r_state == S_RUN);
  assign W_OUT      = W_VALID ? r_win[0] : '0;
  assign W_ROUND    = W_VALID ? r_rcnt : '0;
  assign BLOCK_DONE = (r_state == S_DONE);
  assign BUSY       = (r_state != S_LOAD);

endmodule
